// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared types and limits for the registered N:1 selector
package mux_pkg;

    typedef enum logic {
        MODE_SEL = 1'b0,
        MODE_RR  = 1'b1
    } mode_e;

    localparam int MUX_MAX_N = 16;

endpackage

// File: rtl/mux_arb_reg_rr_arbiter.sv
// rtl/mux_arb_reg_rr_arbiter.sv - combinational rotate-priority search starting after ptr
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int N  = 8,
    localparam int SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [SW-1:0] gnt_idx,
    output logic          gnt_any
);

    // Walk from the farthest position back to ptr+1 so the nearest request is written last.
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int k = N; k >= 1; k--) begin
            if (req[SW'((int'(ptr) + k) % N)]) begin
                gnt_idx = SW'((int'(ptr) + k) % N);
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_arb_reg.sv
// rtl/mux_arb_reg.sv - registered N:1 selector, explicit select or round-robin, valid/ready on all ports
module mux_arb_reg
    import mux_pkg::*;
#(
    parameter  int N  = 8,
    parameter  int W  = 8,
    localparam int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_src,
    output logic           out_valid,
    input  logic           out_ready
);

    logic [W-1:0]  chan [N];
    logic [SW-1:0] ptr;
    logic [SW-1:0] rr_idx;
    logic          rr_any;
    logic [SW-1:0] cand;
    logic          cand_ok;
    logic          can_load;
    logic          gnt;

    for (genvar g = 0; g < N; g++) begin : g_chan
        assign chan[g] = in_data[g*W +: W];
    end

    rr_arbiter #(.N(N)) u_rr (
        .req     (in_valid),
        .ptr     (ptr),
        .gnt_idx (rr_idx),
        .gnt_any (rr_any)
    );

    assign can_load = !out_valid || out_ready;

    // An out-of-range explicit select has no candidate, so nothing is ever readied.
    always_comb begin
        cand    = '0;
        cand_ok = 1'b0;
        if (mode_e'(mode) == MODE_RR) begin
            cand    = rr_idx;
            cand_ok = rr_any;
        end else begin
            cand    = sel;
            cand_ok = int'(sel) < N;
        end
    end

    always_comb begin
        in_ready = '0;
        if (rst_n && can_load && cand_ok) begin
            in_ready = N'(1) << cand;
        end
    end

    assign gnt = |(in_valid & in_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= SW'(N - 1);
        end else if (gnt) begin
            out_valid <= 1'b1;
            out_data  <= chan[cand];
            out_src   <= cand;
            ptr       <= cand;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_arb_reg.sv
// tb/tb_mux_arb_reg.sv - directed self-checking bench for mux_arb_reg (N=8 and N=6 instances)
module tb_mux_arb_reg;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n_a, mode_a, out_valid_a, out_ready_a;
    logic [2:0]  sel_a, out_src_a;
    logic [63:0] in_data_a;
    logic [7:0]  in_valid_a, in_ready_a, out_data_a;

    logic        rst_n_b, mode_b, out_valid_b, out_ready_b;
    logic [2:0]  sel_b, out_src_b;
    logic [47:0] in_data_b;
    logic [5:0]  in_valid_b, in_ready_b;
    logic [7:0]  out_data_b;

    int checks   = 0;
    int failures = 0;

    mux_arb_reg #(.N(8), .W(8)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .mode(mode_a), .sel(sel_a),
        .in_data(in_data_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .out_data(out_data_a), .out_src(out_src_a), .out_valid(out_valid_a),
        .out_ready(out_ready_a)
    );

    mux_arb_reg #(.N(6), .W(8)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .mode(mode_b), .sel(sel_b),
        .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .out_data(out_data_b), .out_src(out_src_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n_a = 1'b0; mode_a = 1'b1; sel_a = 3'd0; out_ready_a = 1'b0;
        in_valid_a = 8'hFF;
        for (int i = 0; i < 8; i++) in_data_a[i*8 +: 8] = 8'hC0 | 8'(i);
        in_data_a[3*8 +: 8] = 8'hA5;

        rst_n_b = 1'b0; mode_b = 1'b0; sel_b = 3'd7; out_ready_b = 1'b1;
        in_valid_b = 6'h3F;
        for (int i = 0; i < 6; i++) in_data_b[i*8 +: 8] = 8'h30 + 8'(i);

        // Reset
        tick();
        chk("rst_in_ready", 64'(in_ready_a), 64'h00);
        tick();
        chk("rst_in_ready2", 64'(in_ready_a), 64'h00);
        chk("rst_out_valid", 64'(out_valid_a), 64'd0);
        chk("rst_out_data", 64'(out_data_a), 64'h00);
        chk("rst_out_src", 64'(out_src_a), 64'd0);

        // Round-robin from reset starts at channel 0
        rst_n_a = 1'b1; out_ready_a = 1'b1;
        #1;
        chk("rr_first_ready", 64'(in_ready_a), 64'h01);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("rr_all_src%0d", k), 64'(out_src_a), 64'(k % 8));
            chk($sformatf("rr_all_valid%0d", k), 64'(out_valid_a), 64'd1);
        end

        // Only channels 2 and 5 valid: alternate
        in_valid_a = 8'h24;
        tick(); chk("rr25_a", 64'(out_src_a), 64'd2);
        tick(); chk("rr25_b", 64'(out_src_a), 64'd5);
        tick(); chk("rr25_c", 64'(out_src_a), 64'd2);
        tick(); chk("rr25_d", 64'(out_src_a), 64'd5);
        chk("rr25_data", 64'(out_data_a), 64'hC5);

        // Backpressure holds the beat and drops all readies
        in_valid_a = 8'hFF; out_ready_a = 1'b0;
        #1;
        chk("bp_ready0", 64'(in_ready_a), 64'h00);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("bp_src%0d", k), 64'(out_src_a), 64'd5);
            chk($sformatf("bp_data%0d", k), 64'(out_data_a), 64'hC5);
            chk($sformatf("bp_ready%0d", k), 64'(in_ready_a), 64'h00);
            chk($sformatf("bp_valid%0d", k), 64'(out_valid_a), 64'd1);
        end
        out_ready_a = 1'b1;
        #1;
        chk("bp_release_ready", 64'(in_ready_a), 64'h40);
        tick();
        chk("bp_release_src", 64'(out_src_a), 64'd6);
        chk("bp_release_valid", 64'(out_valid_a), 64'd1);

        // Explicit select
        mode_a = 1'b0; sel_a = 3'd3;
        #1;
        chk("sel3_ready", 64'(in_ready_a), 64'h08);
        tick();
        chk("sel3_data", 64'(out_data_a), 64'hA5);
        chk("sel3_src", 64'(out_src_a), 64'd3);
        chk("sel3_valid", 64'(out_valid_a), 64'd1);
        chk("sel3_ready_again", 64'(in_ready_a), 64'h08);

        // Selected channel idle: ready still offered, output drains and holds data
        in_valid_a = 8'h00; sel_a = 3'd4;
        #1;
        chk("sel4_idle_ready", 64'(in_ready_a), 64'h10);
        tick();
        chk("drain_valid", 64'(out_valid_a), 64'd0);
        chk("drain_data_hold", 64'(out_data_a), 64'hA5);
        chk("drain_src_hold", 64'(out_src_a), 64'd3);

        // Load channel 4 (ptr=4), then reset while the beat is held
        in_valid_a = 8'hFF;
        tick();
        chk("sel4_src", 64'(out_src_a), 64'd4);
        rst_n_a = 1'b0; out_ready_a = 1'b0;
        #1;
        chk("midrst_ready", 64'(in_ready_a), 64'h00);
        tick();
        chk("midrst_valid", 64'(out_valid_a), 64'd0);
        chk("midrst_src", 64'(out_src_a), 64'd0);
        rst_n_a = 1'b1; mode_a = 1'b1; out_ready_a = 1'b1;
        #1;
        chk("midrst_rr_ready", 64'(in_ready_a), 64'h01);
        tick();
        chk("midrst_rr_src", 64'(out_src_a), 64'd0);

        // N=6: out-of-range select never readies or loads
        rst_n_b = 1'b1;
        #1;
        chk("oor_ready", 64'(in_ready_b), 64'h00);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("oor_valid%0d", k), 64'(out_valid_b), 64'd0);
        end
        mode_b = 1'b1;
        #1;
        chk("oor_rr_ready", 64'(in_ready_b), 64'h01);
        tick(); chk("oor_rr_src0", 64'(out_src_b), 64'd0);
        tick(); chk("oor_rr_src1", 64'(out_src_b), 64'd1);

        // Wrap-around with only the ptr channel valid
        in_valid_b = 6'h20;
        tick(); chk("wrap_src_a", 64'(out_src_b), 64'd5);
        tick(); chk("wrap_src_b", 64'(out_src_b), 64'd5);
        chk("wrap_data", 64'(out_data_b), 64'h35);
        chk("wrap_valid", 64'(out_valid_b), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_arb_reg.md
# mux_arb_reg

Parametrised, registered N:1 data selector with valid/ready handshakes on every input and on the output, generalising the team's fixed 8-input, 8-bit combinational mux. It selects either by an explicit select code or by round-robin arbitration, and holds the chosen beat in a one-entry output register. It sits between multiple producers (register-file/ALU/memory result sources) and a single consumer stage in the MIPS datapath.

## Interface
- N, default 8: number of input channels, 2..16.
- W, default 8: data width per channel, 1..64.
- SW, default $clog2(N): select/source-index width (derived, not overridden).
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous and active-low.
- mode  input  1  0 = explicit select, 1 = round-robin.
- sel  input  SW  channel index used when mode = 0.
- in_data  input  N*W  packed channel data; channel i occupies bits [i*W +: W].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready, combinational.
- out_data  output  W  registered selected data.
- out_src  output  SW  index of the channel that produced out_data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  consumer ready.

## Operation
- Output register state: out_valid, out_data, out_src.
- can_load = !out_valid || out_ready.
- Explicit mode: candidate = sel if sel < N; if sel >= N there is no candidate (replaces the old "x" default). Grant only when in_valid[sel] && can_load.
- Round-robin mode: candidate = first i with in_valid[i], searching from ptr+1 upward and wrapping modulo N. Grant when any in_valid is set && can_load.
- in_ready[i] = can_load && (i == candidate). At most one bit of in_ready is high. In explicit mode, in_ready[sel] is high even if in_valid[sel] is low.
- On grant (in_valid[i] && in_ready[i]): out_data <= channel i data, out_src <= i, out_valid <= 1.
- On out_valid && out_ready with no grant: out_valid <= 0; out_data and out_src hold.
- Round-robin pointer ptr (SW bits): ptr <= granted index on every grant, in either mode. Explicit-mode grants therefore also move the fairness point.
- mode and sel are sampled each cycle. A change affects only the next grant, never a beat already held.

## Timing
- Reset (rst_n low at a rising edge): out_valid = 0, out_data = 0, out_src = 0, ptr = N-1. First round-robin search starts at channel 0. in_ready is all-zero while rst_n is low.
- Latency: 1 cycle from input handshake to out_valid.
- Throughput: 1 beat/cycle while out_ready stays high, because load and drain happen in the same cycle.
- Backpressure: with out_valid = 1 and out_ready = 0, all in_ready = 0, and out_data/out_src stay stable until accepted.
- Wrap-around: ptr = N-1 searches from 0. With only the ptr channel valid, that same channel is granted again.
- Reset mid-transfer: a held beat is discarded with no handshake, and ptr returns to N-1.
- Input data must be stable only in the cycle it is handshaked. No combinational path from in_data to out_data.

## Structure
- Package mux_pkg:
  - mode_e typedef (MODE_SEL = 1'b0, MODE_RR = 1'b1).
  - MUX_MAX_N = 16 constant.
- Sub-module rr_arbiter #(N):
  - inputs: req[N], ptr.
  - outputs: gnt_idx, gnt_any.
  - purely combinational rotate-priority search.
  - instantiated once, used only in mode = 1.
- Top holds the output register, the ptr register and the ready/grant logic.

## Test plan
- Reset then idle:
  - stimulus: rst_n low 2 cycles, then high.
  - required: out_valid = 0, out_data = 0, out_src = 0, in_ready = 0 during reset.
  - required: first round-robin grant with all 8 valid goes to channel 0.
- Explicit mode:
  - stimulus: N=8, W=8, sel=3, in_valid=8'hFF, channel3=8'hA5.
  - required: next cycle out_data = 8'hA5, out_src = 3, out_valid = 1.
  - required: in_ready = 8'b0000_1000 while out_ready = 1.
- Round-robin fairness:
  - stimulus: all 8 valid, out_ready held high 10 cycles.
  - required: out_src sequence 0,1,…,7,0,1.
  - stimulus: only channels 2 and 5 valid.
  - required: alternates 2,5,2,5.
- Backpressure:
  - stimulus: out_ready = 0 for 4 cycles after a beat loads.
  - required: out_data/out_src stable, in_ready = 0.
  - stimulus: release out_ready.
  - required: the next beat loads in the same cycle and out_valid stays 1.
- Out-of-range select:
  - stimulus: N=6, sel=7, all valid.
  - required: in_ready = 0, out_valid never rises.
  - stimulus: switch mode to 1.
  - required: grant resumes from ptr+1.
- Reset mid-operation:
  - stimulus: rst_n low while out_valid = 1 and ptr = 4.
  - required: next cycle out_valid = 0.
  - required: the subsequent round-robin grant goes to channel 0.
